// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the fetch stage: widths, reset PC, NOP encoding,
// FSM state encoding and the opcodes other stages decode.
package fetch_stage_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;
    localparam logic [15:0]     NOP      = 16'h0800;

    // Opcode lives in instr[15:11]; NOP above decodes as OP_NOP.
    localparam int unsigned     OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11110;
    localparam logic [OPCODE_W-1:0] OP_RTI  = 5'b11111;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_INC  = 2'd1,
        PC_LOAD = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: request held until mem_done.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic            mem_rd;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_data;
    logic            mem_done;

    modport master (output mem_rd, output mem_addr, input mem_data, input mem_done);
    modport slave  (input mem_rd, input mem_addr, output mem_data, output mem_done);

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with hold / increment-by-2 / load select.
module fetch_pc_reg
    import fetch_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  pc_sel_e         sel,
    input  logic [PC_W-1:0] load_pc,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2
);

    // Wraps naturally from 16'hFFFE to 16'h0000.
    assign pc_plus2 = pc + 16'd2;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            unique case (sel)
                PC_INC:  pc <= pc_plus2;
                PC_LOAD: pc <= load_pc;
                default: pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, hold-until-done memory read FSM, one-entry skid buffer
// for stalled returns, redirect with discard of an in-flight read, and HALT freeze.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_fetch,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    fetch_stage_if.master      imem,
    output logic [15:0]        instruction,
    output logic [PC_W-1:0]    incremented_pc,
    output logic               inst_mis_align,
    output logic               inst_stall
);

    fetch_state_e    state, state_next;
    pc_sel_e         pc_sel;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] wait_addr;
    logic            hold_valid, hold_valid_next;
    logic [15:0]     hold_instr;
    logic            hold_capture;
    logic            discard, discard_next;
    logic            halt_pend, halt_pend_next;

    fetch_pc_reg u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .sel      (pc_sel),
        .load_pc  (redirect_pc),
        .pc       (pc),
        .pc_plus2 (incremented_pc)
    );

    // A read in flight keeps its original address even after a redirect moves pc.
    assign imem.mem_addr = (state == WAIT) ? wait_addr : pc;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next      = state;
        pc_sel          = PC_HOLD;
        hold_valid_next = hold_valid;
        hold_capture    = 1'b0;
        discard_next    = discard;
        halt_pend_next  = halt_pend;
        imem.mem_rd     = 1'b0;
        instruction     = NOP;
        inst_stall      = 1'b1;
        inst_mis_align  = 1'b0;

        unique case (state)
            FETCH: begin
                if (redirect) begin
                    pc_sel          = PC_LOAD;
                    hold_valid_next = 1'b0;
                end else if (halt) begin
                    state_next = HALTED;
                end else if (pc[0]) begin
                    inst_mis_align = 1'b1;
                    inst_stall     = 1'b0;
                end else if (hold_valid) begin
                    instruction = hold_instr;
                    inst_stall  = 1'b0;
                    if (!stall_fetch) begin
                        pc_sel          = PC_INC;
                        hold_valid_next = 1'b0;
                    end
                end else begin
                    imem.mem_rd = 1'b1;
                    if (imem.mem_done) begin
                        instruction = imem.mem_data;
                        inst_stall  = 1'b0;
                        if (!stall_fetch) begin
                            pc_sel = PC_INC;
                        end else begin
                            hold_capture    = 1'b1;
                            hold_valid_next = 1'b1;
                        end
                    end else begin
                        state_next = WAIT;
                    end
                end
            end

            WAIT: begin
                imem.mem_rd = 1'b1;
                if (redirect) begin
                    pc_sel          = PC_LOAD;
                    hold_valid_next = 1'b0;
                    if (imem.mem_done) begin
                        discard_next   = 1'b0;
                        halt_pend_next = 1'b0;
                        state_next     = halt_pend ? HALTED : FETCH;
                    end else begin
                        discard_next = 1'b1;
                    end
                end else if (halt || halt_pend) begin
                    if (imem.mem_done) begin
                        discard_next   = 1'b0;
                        halt_pend_next = 1'b0;
                        state_next     = HALTED;
                    end else begin
                        halt_pend_next = 1'b1;
                    end
                end else if (imem.mem_done) begin
                    state_next = FETCH;
                    if (discard) begin
                        discard_next = 1'b0;
                    end else begin
                        instruction = imem.mem_data;
                        inst_stall  = 1'b0;
                        if (!stall_fetch) begin
                            pc_sel = PC_INC;
                        end else begin
                            hold_capture    = 1'b1;
                            hold_valid_next = 1'b1;
                        end
                    end
                end
            end

            HALTED: begin
                state_next = HALTED;
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            hold_valid <= 1'b0;
            discard    <= 1'b0;
            halt_pend  <= 1'b0;
        end else begin
            state      <= state_next;
            hold_valid <= hold_valid_next;
            discard    <= discard_next;
            halt_pend  <= halt_pend_next;
        end
    end

    // NOTE: data-path registers are not reset; they are only read while their
    // qualifying flag (hold_valid, state==WAIT) says they hold valid contents.
    always_ff @(posedge clk) begin
        if (hold_capture) begin
            hold_instr <= imem.mem_data;
        end
        if (state != WAIT) begin
            wait_addr <= pc;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined CPU. It holds the PC, drives a multi-cycle instruction memory with a hold-until-done read handshake, and presents one instruction per accepted fetch to the IF/ID pipeline register, together with PC+2, a misalignment flag and a stall flag. It handles branch/jump redirects, including a redirect that arrives while a read is outstanding. It buffers an instruction that returns while decode is stalled, and freezes on HALT.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP, 16'h0800, instruction word emitted when no valid instruction is available
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_fetch  in  1  downstream cannot accept an instruction this cycle (ID stall / data-memory stall)
- redirect  in  1  taken branch/jump/exception; PC must load redirect_pc
- redirect_pc  in  16  redirect target
- halt  in  1  HALT decoded downstream; stop fetching
- mem_rd  out  1  instruction-memory read request
- mem_addr  out  16  read address, equal to pc
- mem_data  in  16  read data, valid when mem_done=1
- mem_done  in  1  read complete; may assert in the same cycle as mem_rd (hit)
- instruction  out  16  fetched instruction, or NOP
- incremented_pc  out  16  address of the instruction + 2
- inst_mis_align  out  1  pc[0]=1; the instruction slot is invalid
- inst_stall  out  1  no valid instruction this cycle; IF/ID inserts a bubble

## Operation
- State: pc[15:0], FSM {FETCH, WAIT, HALTED}, hold_valid plus hold_instr[15:0] (skid buffer), discard flag.
- Action priority each cycle: rst > redirect > halt > stall_fetch > normal.
- FETCH:
  - If pc[0]=1: mem_rd=0, inst_mis_align=1, instruction=NOP, inst_stall=0 so the flag propagates. pc holds until redirect.
  - Else if hold_valid: instruction=hold_instr, mem_rd=0, inst_stall=0. If ~stall_fetch, then pc<=pc+2 and hold_valid<=0.
  - Else: mem_rd=1, mem_addr=pc.
    - On mem_done: instruction=mem_data, inst_stall=0.
      - If ~stall_fetch: pc<=pc+2.
      - Else: hold_instr<=mem_data and hold_valid<=1; pc holds.
    - Without mem_done: go to WAIT, inst_stall=1.
- WAIT:
  - mem_rd stays 1 and mem_addr stays stable until mem_done.
  - On mem_done:
    - If discard=0: behave as a FETCH completion, then go to FETCH.
    - If discard=1: drop the data, inst_stall=1, clear discard, go to FETCH.
- Redirect:
  - pc<=redirect_pc and hold_valid<=0.
  - The current-cycle instruction is replaced by NOP with inst_stall=1.
  - If in WAIT without mem_done, set discard=1 and stay in WAIT. The read completes to the old address and its data is dropped.
- halt:
  - Enter HALTED; pc frozen; mem_rd=0; instruction=NOP; inst_stall=1.
  - HALTED exits only on rst.
  - If halt arrives during WAIT, keep mem_rd=1 until mem_done, ignore the data, then enter HALTED.
- incremented_pc = pc + 2, modulo 2^16 (16'hFFFE -> 16'h0000). It always reflects the pc of the presented instruction.

## Timing
- Reset values:
  - pc=RESET_PC, state FETCH, hold_valid=0, discard=0.
  - Outputs in the first post-reset cycle: mem_rd=1, mem_addr=RESET_PC; instruction=NOP and inst_stall=1 until mem_done.
- Hit latency: 0 cycles. The instruction is valid in the same cycle as mem_rd plus mem_done, and is captured by IF/ID on that edge.
- Miss latency: N cycles of inst_stall=1, where N = cycles until mem_done.
- Redirect takes effect on the next edge. The first read of redirect_pc issues the cycle after redirect, or the cycle after the discarded mem_done.
- Held instruction: re-presented every cycle while stall_fetch=1, with no new memory read.
- Reset mid-WAIT: state returns to FETCH immediately; the outstanding read is abandoned and mem_rd restarts at RESET_PC.
- redirect and halt in the same cycle: redirect wins, halt is ignored.

## Structure
- Shared CPU package holds: NOP encoding, PC width 16, FSM state encoding, and the opcode constants for HALT/RTI used elsewhere.
- One natural sub-module: fetch_pc_reg, the 16-bit PC register with load/increment/hold select built from the existing dff cells. The FSM and skid buffer stay in fetch_stage.

## Test plan
- Sequential hits: reset, then mem_done=1 every cycle, with mem_data = 16'h4000+i. Required: pc 0000, 0002, 0004, …; instruction matches each data word; incremented_pc = pc+2; inst_stall=0 from cycle 0.
- 3-cycle miss: mem_done after 3 cycles at pc=0x0010. Required: inst_stall=1 for 3 cycles, mem_addr held at 0x0010, instruction valid in cycle 4, pc→0x0012.
- Stall on return: stall_fetch=1 for 2 cycles, coinciding with mem_done, data 0xA5A5. Required: 0xA5A5 presented 3 cycles; only one mem_rd transaction; pc advances after stall_fetch drops.
- Redirect during miss: redirect to 0x0100 while WAIT at 0x0020. Required: discarded data never appears (inst_stall=1); next mem_addr=0x0100.
- Misalign and wrap: redirect to 0x0033 gives inst_mis_align=1, NOP, mem_rd=0. Redirect to 0xFFFE with a hit gives incremented_pc=0x0000.
- Halt: halt asserted during WAIT. Required: read completes, then mem_rd=0, inst_stall=1 indefinitely; rst restarts at RESET_PC.
